uvme_axil_st_slice: RTL and testbench

Registered AXI-Lite slice for the AXI-Lite self-test environment. It sits between the master agent's interface (`mstr_if`) and the slave agent's interface (`slv_if`), so the self-test checker sees a real pipelined path with latency and backpressure instead of a wire. Each of the five channels gets a two-entry skid buffer. The slice also caps the number of in-flight write and read transactions and reports the live counts.

---
 rtl/uvme_axil_st_slice_if.sv | 40 ++++
 rtl/uvme_axil_st_slice.sv | 213 +++++++++++++++++++++
 tb/tb_uvme_axil_st_slice.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uvme_axil_st_slice_if.sv
// uvma_axil_if: AXI-Lite bus bundle shared by the self-test agents and the
// registered slice.
//   master modport : drives AW/W/AR valid+payload, bready, rready
//   slave  modport : drives AW/W/AR ready, B/R valid+payload
interface uvma_axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/uvme_axil_st_slice.sv
// uvme_axil_st_slice: registered AXI-Lite slice with a two-entry skid buffer
// per channel and a cap on in-flight transactions per direction.
//   clk            : single clock
//   reset_n        : asynchronous active-low reset
//   mstr_if        : upstream bus, slice acts as AXI-Lite slave
//   slv_if         : downstream bus, slice acts as AXI-Lite master
//   wr_outstanding : writes issued downstream awaiting upstream B handshake
//   rd_outstanding : reads issued downstream awaiting upstream R handshake

// Two-entry skid buffer. Input ready comes straight from a flop, so there is
// no combinational path from out_ready back to in_ready.
module uvme_axil_st_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_en,     // qualifies out_valid (outstanding cap)
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             out_v_q, out_v_d;
  logic             sk_v_q, sk_v_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;
  logic [WIDTH-1:0] sk_d_q, sk_d_d;
  logic             in_hs, out_hs;

  assign in_ready  = rdy_q;
  assign out_valid = out_v_q && out_en;
  assign out_data  = out_d_q;
  assign in_hs     = in_valid && rdy_q;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned; that is what keeps it free of inferred latches.
    out_v_d = out_v_q;
    out_d_d = out_d_q;
    sk_v_d  = sk_v_q;
    sk_d_d  = sk_d_q;

    if (out_hs) begin
      if (sk_v_q) begin
        out_d_d = sk_d_q;
        sk_v_d  = 1'b0;
      end else begin
        out_v_d = 1'b0;
      end
    end

    // in_hs implies the skid is empty because ready mirrors !sk_v.
    if (in_hs) begin
      if ((!out_v_q || out_hs) && !sk_v_q) begin
        out_v_d = 1'b1;
        out_d_d = in_data;
      end else begin
        sk_v_d  = 1'b1;
        sk_d_d  = in_data;
      end
    end

    // Held at 0 through reset, so ready first rises on the edge after release.
    rdy_d = !sk_v_d;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  // Payload registers are reset as well: the bus must read all-zero in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_v_q <= 1'b0;
      sk_v_q  <= 1'b0;
      rdy_q   <= 1'b0;
      out_d_q <= '0;
      sk_d_q  <= '0;
    end else begin
      out_v_q <= out_v_d;
      sk_v_q  <= sk_v_d;
      rdy_q   <= rdy_d;
      out_d_q <= out_d_d;
      sk_d_q  <= sk_d_d;
    end
  end
endmodule

module uvme_axil_st_slice #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  uvma_axil_if.slave         mstr_if,
  uvma_axil_if.master        slv_if,
  output logic [3:0]         wr_outstanding,
  output logic [3:0]         rd_outstanding
);
  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam int         AX_WIDTH   = ADDR_WIDTH + 3;
  localparam int         W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
  localparam int         R_WIDTH    = DATA_WIDTH + 2;
  localparam logic [3:0] MAX_CNT    = 4'(MAX_OUTSTANDING);

  logic [AX_WIDTH-1:0] aw_out, ar_out;
  logic [W_WIDTH-1:0]  w_out;
  logic [R_WIDTH-1:0]  r_out;
  logic [1:0]          b_out;
  logic                aw_vld, ar_vld, b_vld, r_vld;
  logic [3:0]          wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                aw_dn_hs, ar_dn_hs, b_up_hs, r_up_hs;

  // Forward channels: AW and AR are held back once the cap is reached.
  uvme_axil_st_skid #(.WIDTH(AX_WIDTH)) u_aw (
    .clk(clk), .reset_n(reset_n),
    .in_valid(mstr_if.awvalid), .in_ready(mstr_if.awready),
    .in_data({mstr_if.awaddr, mstr_if.awprot}),
    .out_en(wr_cnt_q < MAX_CNT), .out_valid(aw_vld),
    .out_ready(slv_if.awready), .out_data(aw_out)
  );

  uvme_axil_st_skid #(.WIDTH(W_WIDTH)) u_w (
    .clk(clk), .reset_n(reset_n),
    .in_valid(mstr_if.wvalid), .in_ready(mstr_if.wready),
    .in_data({mstr_if.wdata, mstr_if.wstrb}),
    .out_en(1'b1), .out_valid(slv_if.wvalid),
    .out_ready(slv_if.wready), .out_data(w_out)
  );

  uvme_axil_st_skid #(.WIDTH(AX_WIDTH)) u_ar (
    .clk(clk), .reset_n(reset_n),
    .in_valid(mstr_if.arvalid), .in_ready(mstr_if.arready),
    .in_data({mstr_if.araddr, mstr_if.arprot}),
    .out_en(rd_cnt_q < MAX_CNT), .out_valid(ar_vld),
    .out_ready(slv_if.arready), .out_data(ar_out)
  );

  // Reverse channels: responses forwarded untouched, error codes included.
  uvme_axil_st_skid #(.WIDTH(2)) u_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(slv_if.bvalid), .in_ready(slv_if.bready),
    .in_data(slv_if.bresp),
    .out_en(1'b1), .out_valid(b_vld),
    .out_ready(mstr_if.bready), .out_data(b_out)
  );

  uvme_axil_st_skid #(.WIDTH(R_WIDTH)) u_r (
    .clk(clk), .reset_n(reset_n),
    .in_valid(slv_if.rvalid), .in_ready(slv_if.rready),
    .in_data({slv_if.rdata, slv_if.rresp}),
    .out_en(1'b1), .out_valid(r_vld),
    .out_ready(mstr_if.rready), .out_data(r_out)
  );

  assign slv_if.awvalid = aw_vld;
  assign slv_if.awaddr  = aw_out[AX_WIDTH-1:3];
  assign slv_if.awprot  = aw_out[2:0];
  assign slv_if.wdata   = w_out[W_WIDTH-1:STRB_WIDTH];
  assign slv_if.wstrb   = w_out[STRB_WIDTH-1:0];
  assign slv_if.arvalid = ar_vld;
  assign slv_if.araddr  = ar_out[AX_WIDTH-1:3];
  assign slv_if.arprot  = ar_out[2:0];
  assign mstr_if.bvalid = b_vld;
  assign mstr_if.bresp  = b_out;
  assign mstr_if.rvalid = r_vld;
  assign mstr_if.rdata  = r_out[R_WIDTH-1:2];
  assign mstr_if.rresp  = r_out[1:0];

  assign aw_dn_hs = aw_vld && slv_if.awready;
  assign ar_dn_hs = ar_vld && slv_if.arready;
  assign b_up_hs  = b_vld && mstr_if.bready;
  assign r_up_hs  = r_vld && mstr_if.rready;

  // Simultaneous issue and retire cancel; a stray response at zero holds.
  function automatic logic [3:0] next_count(input logic [3:0] cnt,
                                            input logic inc, input logic dec);
    logic [3:0] nxt;
    nxt = cnt;
    if (inc && !dec)                       nxt = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0)   nxt = cnt - 4'd1;
    return nxt;
  endfunction

  always_comb begin
    wr_cnt_d = next_count(wr_cnt_q, aw_dn_hs, b_up_hs);
    rd_cnt_d = next_count(rd_cnt_q, ar_dn_hs, r_up_hs);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= 4'd0;
      rd_cnt_q <= 4'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;

  // A response with nothing outstanding means the downstream agent misbehaved.
  a_no_b_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(b_up_hs && wr_cnt_q == 4'd0))
    else $error("uvme_axil_st_slice: B response with no write outstanding");

  a_no_r_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(r_up_hs && rd_cnt_q == 4'd0))
    else $error("uvme_axil_st_slice: R response with no read outstanding");
endmodule

// File: tb/tb_uvme_axil_st_slice.sv
// Testbench for uvme_axil_st_slice. Stimulus pushes expected beats into
// per-channel queues; a negedge monitor pops and compares on every output
// handshake. A second instance with a cap of 2 exercises the outstanding limit.
module tb_uvme_axil_st_slice;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uvma_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mstr_if ();
  uvma_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) slv_if ();
  uvma_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cmstr_if ();
  uvma_axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cslv_if ();

  logic [3:0] wr_out, rd_out, c_wr_out, c_rd_out;

  uvme_axil_st_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset_n(reset_n), .mstr_if(mstr_if), .slv_if(slv_if),
    .wr_outstanding(wr_out), .rd_outstanding(rd_out)
  );

  uvme_axil_st_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut_cap (
    .clk(clk), .reset_n(reset_n), .mstr_if(cmstr_if), .slv_if(cslv_if),
    .wr_outstanding(c_wr_out), .rd_outstanding(c_rd_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [34:0] exp_ar[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  int c_ar_dn = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s at %0t", name, why, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every output handshake against its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (slv_if.awvalid && slv_if.awready) begin
        if (exp_aw.size() == 0) flag("sb_aw", "unexpected beat");
        else check("sb_aw", 64'({slv_if.awaddr, slv_if.awprot}), 64'(exp_aw.pop_front()));
      end
      if (slv_if.wvalid && slv_if.wready) begin
        if (exp_w.size() == 0) flag("sb_w", "unexpected beat");
        else check("sb_w", 64'({slv_if.wdata, slv_if.wstrb}), 64'(exp_w.pop_front()));
      end
      if (slv_if.arvalid && slv_if.arready) begin
        if (exp_ar.size() == 0) flag("sb_ar", "unexpected beat");
        else check("sb_ar", 64'({slv_if.araddr, slv_if.arprot}), 64'(exp_ar.pop_front()));
      end
      if (mstr_if.bvalid && mstr_if.bready) begin
        if (exp_b.size() == 0) flag("sb_b", "unexpected beat");
        else check("sb_b", 64'(mstr_if.bresp), 64'(exp_b.pop_front()));
      end
      if (mstr_if.rvalid && mstr_if.rready) begin
        if (exp_r.size() == 0) flag("sb_r", "unexpected beat");
        else check("sb_r", 64'({mstr_if.rdata, mstr_if.rresp}), 64'(exp_r.pop_front()));
      end
      if (cslv_if.arvalid && cslv_if.arready) c_ar_dn++;
    end
  end

  task automatic mstr_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done, w_done, aw_hs, w_hs;
    int guard;
    aw_done = 0; w_done = 0; guard = 0;
    mstr_if.awvalid = 1'b1; mstr_if.awaddr = addr; mstr_if.awprot = 3'd0;
    mstr_if.wvalid  = 1'b1; mstr_if.wdata  = data; mstr_if.wstrb  = strb;
    exp_aw.push_back({addr, 3'd0});
    exp_w.push_back({data, strb});
    while (!(aw_done && w_done) && guard < 20) begin
      aw_hs = mstr_if.awvalid && mstr_if.awready;
      w_hs  = mstr_if.wvalid && mstr_if.wready;
      tick();
      guard++;
      if (aw_hs) begin aw_done = 1; mstr_if.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; mstr_if.wvalid  = 1'b0; end
    end
    if (!(aw_done && w_done)) flag("mstr_write", "timed out");
  endtask

  task automatic mstr_read(input logic [31:0] addr);
    bit hs;
    int guard;
    guard = 0; hs = 0;
    mstr_if.arvalid = 1'b1; mstr_if.araddr = addr; mstr_if.arprot = 3'd0;
    exp_ar.push_back({addr, 3'd0});
    while (!hs && guard < 20) begin
      hs = mstr_if.arready;
      tick();
      guard++;
    end
    mstr_if.arvalid = 1'b0;
    if (!hs) flag("mstr_read", "timed out");
  endtask

  task automatic slv_b(input logic [1:0] resp);
    bit hs;
    int guard;
    guard = 0; hs = 0;
    slv_if.bvalid = 1'b1; slv_if.bresp = resp;
    exp_b.push_back(resp);
    while (!hs && guard < 20) begin
      hs = slv_if.bready;
      tick();
      guard++;
    end
    slv_if.bvalid = 1'b0;
    if (!hs) flag("slv_b", "timed out");
  endtask

  task automatic slv_r(input logic [31:0] data, input logic [1:0] resp);
    bit hs;
    int guard;
    guard = 0; hs = 0;
    slv_if.rvalid = 1'b1; slv_if.rdata = data; slv_if.rresp = resp;
    exp_r.push_back({data, resp});
    while (!hs && guard < 20) begin
      hs = slv_if.rready;
      tick();
      guard++;
    end
    slv_if.rvalid = 1'b0;
    if (!hs) flag("slv_r", "timed out");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vld_rdy"}, 64'({mstr_if.awready, mstr_if.wready, mstr_if.arready,
          mstr_if.bvalid, mstr_if.rvalid, slv_if.awvalid, slv_if.wvalid,
          slv_if.arvalid, slv_if.bready, slv_if.rready}), 64'd0);
    check({tag, "_payload_any"}, 64'(|{mstr_if.rdata, mstr_if.rresp, mstr_if.bresp,
          slv_if.awaddr, slv_if.awprot, slv_if.wdata, slv_if.wstrb,
          slv_if.araddr, slv_if.arprot}), 64'd0);
    check({tag, "_counters"}, 64'({wr_out, rd_out, c_wr_out, c_rd_out}), 64'd0);
  endtask

  task automatic check_readies(input string tag, input logic [4:0] exp);
    check(tag, 64'({mstr_if.awready, mstr_if.wready, mstr_if.arready,
          slv_if.bready, slv_if.rready}), 64'(exp));
  endtask

  task automatic idle_agents();
    mstr_if.awvalid = 1'b0; mstr_if.awaddr = '0; mstr_if.awprot = '0;
    mstr_if.wvalid  = 1'b0; mstr_if.wdata  = '0; mstr_if.wstrb  = '0;
    mstr_if.arvalid = 1'b0; mstr_if.araddr = '0; mstr_if.arprot = '0;
    mstr_if.bready  = 1'b1; mstr_if.rready = 1'b1;
    slv_if.awready  = 1'b1; slv_if.wready  = 1'b1; slv_if.arready = 1'b1;
    slv_if.bvalid   = 1'b0; slv_if.bresp   = '0;
    slv_if.rvalid   = 1'b0; slv_if.rdata   = '0; slv_if.rresp   = '0;
    cmstr_if.awvalid = 1'b0; cmstr_if.awaddr = '0; cmstr_if.awprot = '0;
    cmstr_if.wvalid  = 1'b0; cmstr_if.wdata  = '0; cmstr_if.wstrb  = '0;
    cmstr_if.arvalid = 1'b0; cmstr_if.araddr = '0; cmstr_if.arprot = '0;
    cmstr_if.bready  = 1'b1; cmstr_if.rready = 1'b1;
    cslv_if.awready  = 1'b1; cslv_if.wready  = 1'b1; cslv_if.arready = 1'b1;
    cslv_if.bvalid   = 1'b0; cslv_if.bresp   = '0;
    cslv_if.rvalid   = 1'b0; cslv_if.rdata   = '0; cslv_if.rresp   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    idle_agents();

    // Reset state and synchronous release.
    #12;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_readies("readies_before_edge", 5'h00);
    tick();
    check_readies("readies_after_edge", 5'h1F);

    // Single write, no backpressure.
    mstr_if.awvalid = 1'b1; mstr_if.awaddr = 32'h0000_0010; mstr_if.awprot = 3'd0;
    mstr_if.wvalid  = 1'b1; mstr_if.wdata  = 32'hDEAD_BEEF; mstr_if.wstrb  = 4'hF;
    exp_aw.push_back({32'h0000_0010, 3'd0});
    exp_w.push_back({32'hDEAD_BEEF, 4'hF});
    tick();
    mstr_if.awvalid = 1'b0; mstr_if.wvalid = 1'b0;
    check("wr1_dn_valid_c1", 64'({slv_if.awvalid, slv_if.wvalid}), 64'h3);
    check("wr1_cnt_c1", 64'(wr_out), 64'd0);
    tick();
    check("wr1_cnt_after_aw", 64'(wr_out), 64'd1);
    check("wr1_aw_dropped", 64'(slv_if.awvalid), 64'd0);
    tick();
    slv_if.bvalid = 1'b1; slv_if.bresp = 2'b00;
    exp_b.push_back(2'b00);
    tick();
    slv_if.bvalid = 1'b0;
    check("wr1_bvalid_c4", 64'(mstr_if.bvalid), 64'd1);
    check("wr1_cnt_before_b", 64'(wr_out), 64'd1);
    tick();
    check("wr1_cnt_after_b", 64'(wr_out), 64'd0);
    check("wr1_bvalid_gone", 64'(mstr_if.bvalid), 64'd0);

    // Read backpressure: three reads, master stalls R.
    mstr_read(32'h0000_0100);
    mstr_read(32'h0000_0104);
    mstr_read(32'h0000_0108);
    repeat (3) tick();
    check("rd_cnt_3", 64'(rd_out), 64'd3);
    mstr_if.rready = 1'b0;
    slv_r(32'h1, 2'b00);
    slv_r(32'h2, 2'b00);
    check("rbp_rready_fell", 64'(slv_if.rready), 64'd0);
    slv_if.rvalid = 1'b1; slv_if.rdata = 32'h3; slv_if.rresp = 2'b00;
    exp_r.push_back({32'h3, 2'b00});
    for (int i = 0; i < 3; i++) begin
      check("rbp_stall_rdata", 64'({mstr_if.rvalid, mstr_if.rdata}), 64'({1'b1, 32'h1}));
      check("rbp_stall_rready", 64'(slv_if.rready), 64'd0);
      tick();
    end
    mstr_if.rready = 1'b1;
    begin
      bit hs;
      int guard;
      hs = 0; guard = 0;
      while (!hs && guard < 10) begin
        hs = slv_if.rready;
        tick();
        guard++;
      end
      if (!hs) flag("rbp_beat3", "timed out");
    end
    slv_if.rvalid = 1'b0;
    repeat (2) tick();
    check("rbp_cnt_drained", 64'(rd_out), 64'd0);

    // Simultaneous AW issue and B retire with one write outstanding; SLVERR passthrough.
    mstr_write(32'h0000_0020, 32'h1111_1111, 4'hF);
    repeat (2) tick();
    check("sim_cnt_pre", 64'(wr_out), 64'd1);
    slv_if.bvalid = 1'b1; slv_if.bresp = 2'b10;
    exp_b.push_back(2'b10);
    mstr_if.awvalid = 1'b1; mstr_if.awaddr = 32'h0000_0024; mstr_if.awprot = 3'd0;
    mstr_if.wvalid  = 1'b1; mstr_if.wdata  = 32'h2222_2222; mstr_if.wstrb  = 4'h5;
    exp_aw.push_back({32'h0000_0024, 3'd0});
    exp_w.push_back({32'h2222_2222, 4'h5});
    tick();
    slv_if.bvalid = 1'b0; mstr_if.awvalid = 1'b0; mstr_if.wvalid = 1'b0;
    check("sim_both_valid", 64'({mstr_if.bvalid, slv_if.awvalid}), 64'h3);
    check("sim_bresp_slverr", 64'(mstr_if.bresp), 64'h2);
    tick();
    check("sim_cnt_same_cycle", 64'(wr_out), 64'd1);
    slv_b(2'b00);
    repeat (2) tick();
    check("sim_cnt_drained", 64'(wr_out), 64'd0);

    // DECERR read passthrough.
    mstr_read(32'h0000_0030);
    repeat (2) tick();
    slv_r(32'hCAFE_F00D, 2'b11);
    repeat (2) tick();
    check("rresp_cnt_drained", 64'(rd_out), 64'd0);

    // Mid-operation asynchronous reset with two writes in flight.
    mstr_write(32'h0000_0040, 32'h4444_4444, 4'hF);
    mstr_write(32'h0000_0044, 32'h5555_5555, 4'hF);
    repeat (3) tick();
    check("rst_cnt_pre", 64'(wr_out), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_b.delete(); exp_r.delete();
    idle_agents();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check_readies("midrst_readies", 5'h1F);
    mstr_write(32'h0000_0050, 32'hA5A5_A5A5, 4'h3);
    repeat (2) tick();
    check("post_rst_cnt_1", 64'(wr_out), 64'd1);
    slv_b(2'b01);
    repeat (2) tick();
    check("post_rst_cnt_0", 64'(wr_out), 64'd0);

    // Outstanding cap on the MAX_OUTSTANDING=2 instance.
    cslv_if.rvalid = 1'b0;
    base = c_ar_dn;
    cmstr_if.arvalid = 1'b1;
    cmstr_if.araddr = 32'h0000_0200; tick();
    cmstr_if.araddr = 32'h0000_0204; tick();
    cmstr_if.araddr = 32'h0000_0208; tick();
    cmstr_if.arvalid = 1'b0;
    repeat (4) tick();
    check("cap_dn_count_2", 64'(c_ar_dn - base), 64'd2);
    check("cap_arvalid_low", 64'(cslv_if.arvalid), 64'd0);
    check("cap_rd_cnt_2", 64'(c_rd_out), 64'd2);
    cslv_if.rvalid = 1'b1; cslv_if.rdata = 32'h1; cslv_if.rresp = 2'b00;
    tick();
    cslv_if.rvalid = 1'b0;
    check("cap_still_blocked", 64'({cslv_if.arvalid, c_rd_out}), 64'({1'b0, 4'd2}));
    tick();
    check("cap_rd_cnt_after_r", 64'(c_rd_out), 64'd1);
    check("cap_ar3_presented", 64'({cslv_if.arvalid, cslv_if.araddr}), 64'({1'b1, 32'h0000_0208}));
    tick();
    check("cap_dn_count_3", 64'(c_ar_dn - base), 64'd3);
    check("cap_rd_cnt_back_2", 64'(c_rd_out), 64'd2);
    check("cap_wr_cnt_idle", 64'(c_wr_out), 64'd0);

    repeat (2) tick();
    check("sb_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()
          + exp_b.size() + exp_r.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
